// File: rtl/count_enable_gen.sv
// count_enable_gen: run/stop and single-step count-enable pulse generator driven by two push buttons.
// Define COUNT_ENABLE_GEN_DEBOUNCE_EN to include the key debouncers; without it the synchronized
// keys are used directly and DB_CYCLES is ignored.
module count_enable_gen #(
  parameter int unsigned DIV       = 50000000,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Key_Run,
  input  logic        Key_Step,
  output logic        En,
  output logic        Running,
  output logic [25:0] Phase
);
  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;
  localparam logic [25:0] PH_LAST = 26'(DIV - 1);
  if (DIV < 2 || DIV > 26'h3ff_ffff) begin : g_div_chk
    $error("count_enable_gen: DIV out of range");
  end
  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_db_chk
    $error("count_enable_gen: DB_CYCLES out of range");
  end
  // bit 0 is the run key, bit 1 the step key
  logic [1:0] key_s1_q, key_s2_q, filt_q, filt_d, press_q, press_d;
  state_t      state_q, state_d;
  logic [25:0] phase_q, phase_d;
  logic        en_q, en_d;
  // two-flop synchronizers, released (1) in reset
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      key_s1_q <= '1;
      key_s2_q <= '1;
    end else begin
      key_s1_q <= {Key_Step, Key_Run};
      key_s2_q <= key_s1_q;
    end
  end
`ifdef COUNT_ENABLE_GEN_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
  logic [1:0][7:0] cnt_q, cnt_d;
  // filtered level flips after DB_CYCLES consecutive disagreeing cycles; any agreement restarts the run
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k]  = (key_s2_q[k] != filt_q[k] && cnt_q[k] != DB_LAST) ? cnt_q[k] + 8'd1 : 8'd0;
      filt_d[k] = (key_s2_q[k] != filt_q[k] && cnt_q[k] == DB_LAST) ? key_s2_q[k] : filt_q[k];
    end
  end
  // debouncer state
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      filt_q <= '1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign filt_q = key_s2_q;
  assign filt_d = key_s1_q;
`endif
  // press events: registered 1->0 edge of the filtered level, so press_d is a one-cycle look-ahead
  assign press_d = filt_q & ~filt_d;
  // FSM next state, prescaler and enable; a run press arriving next cycle cancels a periodic En
  always_comb begin
    state_d = press_q[0] ? (state_q == RUN ? STOP : RUN) : state_q;
    phase_d = (state_q == RUN && state_d == RUN && phase_q != PH_LAST) ? phase_q + 26'd1 : '0;
    en_d    = (state_d == RUN && phase_d == PH_LAST && !press_d[0]) ||
              (state_q == STOP && press_q[1] && !press_q[0]);
  end
  // state, prescaler, enable and press registers
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      press_q <= '0;
      state_q <= STOP;
      phase_q <= '0;
      en_q    <= 1'b0;
    end else begin
      press_q <= press_d;
      state_q <= state_d;
      phase_q <= phase_d;
      en_q    <= en_d;
    end
  end
  assign En      = en_q;
  assign Running = (state_q == RUN);
  assign Phase   = phase_q;
endmodule

// File: tb/tb_count_enable_gen.sv
// tb_count_enable_gen: directed self-checking bench for count_enable_gen with DIV=4, DB_CYCLES=3.
module tb_count_enable_gen;
  localparam int DIV = 4;
  localparam int DB  = 3;
`ifdef COUNT_ENABLE_GEN_DEBOUNCE_EN
  localparam int LAT = DB;
`else
  localparam int LAT = 0;
`endif
  localparam int R = 2 + LAT;
  typedef struct {
    logic rk;
    logic sk;
    logic en;
    logic run;
    int   ph;
  } vec_t;
  logic        Clk = 1'b0, Clr = 1'b1, Key_Run = 1'b1, Key_Step = 1'b1;
  logic        En, Running;
  logic [25:0] Phase;
  int checks = 0, failures = 0, en_cnt = 0;
  vec_t tbl[$];
  always #5 Clk = ~Clk;
  count_enable_gen #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .Clk(Clk), .Clr(Clr), .Key_Run(Key_Run), .Key_Step(Key_Step),
    .En(En), .Running(Running), .Phase(Phase)
  );
  task automatic check(input string nm, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got en=%0b run=%0b phase=%0d, want en=%0b run=%0b phase=%0d",
               nm, act[27], act[26], act[25:0], exp[27], exp[26], exp[25:0]);
    end
  endtask
  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic rk, input logic sk, input logic e_en, input logic e_run,
                     input int e_ph, input string nm);
    Key_Run  = rk;
    Key_Step = sk;
    @(posedge Clk);
    @(negedge Clk);
    if (En) en_cnt++;
    check(nm, {En, Running, Phase}, {e_en, e_run, 26'(e_ph)});
  endtask
  initial begin
    vec_t v;
    int n_p, pc, ph;
    logic run;
    for (int i = 0; i < R + 40; i++) begin
      v.rk  = (i < 10) ? 1'b0 : 1'b1;
      v.sk  = 1'b1;
      v.run = (i >= R);
      v.ph  = v.run ? (i - R) % DIV : 0;
      v.en  = v.run && v.ph == DIV - 1;
      tbl.push_back(v);
    end
    #1 Clr = 1'b0;
    #1 check("reset_async", {En, Running, Phase}, 28'd0);
    repeat (2) begin
      @(negedge Clk);
      check("reset_hold", {En, Running, Phase}, 28'd0);
    end
    Clr = 1'b1;
`ifdef COUNT_ENABLE_GEN_DEBOUNCE_EN
    for (int i = 0; i < 10; i++) cyc(i < 2 ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, 0, "glitch_rejected");
`else
    cyc(0, 1, 0, 0, 0, "short_press");
    cyc(1, 1, 0, 0, 0, "short_press");
    cyc(1, 1, 0, 1, 0, "short_press_run");
    cyc(1, 1, 0, 1, 1, "short_press_run");
    cyc(0, 1, 0, 1, 2, "short_stop");
    cyc(1, 1, 0, 1, 3, "short_stop_suppress");
    cyc(1, 1, 0, 0, 0, "short_stopped");
    cyc(1, 1, 0, 0, 0, "short_stopped");
`endif
    en_cnt = 0;
    foreach (tbl[i]) cyc(tbl[i].rk, tbl[i].sk, tbl[i].en, tbl[i].run, tbl[i].ph, "run_periodic");
    check_int("run_en_count", en_cnt, 10);
    en_cnt = 0;
    for (int n = 0; n < 16; n++)
      cyc(1, n < 5 ? 1'b0 : 1'b1, n % DIV == DIV - 1, 1, n % DIV, "step_in_run");
    check_int("step_in_run_en_count", en_cnt, 4);
    n_p = 16 + (6 - LAT) % 4;
    pc  = n_p + 1 + LAT;
    for (int n = 16; n <= n_p + 12; n++) begin
      run = (n <= pc);
      ph  = run ? n % DIV : 0;
      cyc((n >= n_p && n < n_p + 5) ? 1'b0 : 1'b1, 1, run && ph == DIV - 1 && n != pc, run, ph,
          n == pc ? "stop_at_last_phase" : "stop_seq");
    end
    en_cnt = 0;
    for (int m = 0; m < 14; m++) cyc(1, m < 5 ? 1'b0 : 1'b1, m == 2 + LAT, 0, 0, "step_in_stop");
    check_int("step_in_stop_en_count", en_cnt, 1);
    for (int m = 0; m <= R + 6; m++) begin
      run = (m >= R);
      ph  = run ? (m - R) % DIV : 0;
      cyc(m < 5 ? 1'b0 : 1'b1, m < 5 ? 1'b0 : 1'b1, run && ph == DIV - 1, run, ph, "run_and_step");
    end
    Clr = 1'b0;
    #1 check("clr_mid_run", {En, Running, Phase}, 28'd0);
    @(negedge Clk);
    Clr = 1'b1;
    for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 0, "quiet_after_clr");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
